ts_os_gen: RTL and testbench
============================

// Module: ts_os_gen
// PURPOSE
//  Parametrised TS1/TS2 training ordered-set generator for the LTSSM transmit path. Emits 16-symbol
//  ordered sets on LANE_NUM lanes, one symbol per lane per clk, with per-lane lane numbers, PAD
//  substitution, N_FTS/rate/training-control fields and a repeat count. Sits between the LTSSM
//  controller (request side) and the per-lane symbol encoders (tx side).
// PARAMETERS
//  LANE_NUM   4   number of lanes driven in parallel
//  CNT_W      16  width of repeat count and sent-OS counter
// PORTS
//  clk         in   1            1GHz system clock
//  rst         in   1            asynchronous, active-high reset
//  ts_start    in   1            pulse: begin a burst (ignored while ts_busy=1)
//  ts_stop     in   1            pulse: end continuous burst after the current OS
//  ts_type     in   1            0=TS1 (ident 8'h4A), 1=TS2 (ident 8'h45)
//  ts_count    in   CNT_W        OS to send; 0 = continuous until ts_stop
//  link_num    in   8            symbol 1 value
//  lane_base   in   8            symbol 2 value on lane 0; lane i sends lane_base+i (8-bit wrap)
//  pad_link    in   1            symbol 1 = PAD (8'hF7, K)
//  pad_lane    in   1            symbol 2 = PAD (8'hF7, K)
//  n_fts       in   8            symbol 3
//  rate_id     in   8            symbol 4
//  train_ctl   in   8            symbol 5
//  tx_sym      out  8*LANE_NUM   lane i on [8i+7:8i]
//  tx_k        out  LANE_NUM     K-character flag per lane
//  tx_valid    out  1            tx_sym/tx_k valid
//  os_first    out  1            high with symbol 0 (COM) of each OS
//  ts_busy     out  1            burst in progress
//  ts_done     out  1            one-cycle pulse after final symbol 15 of a burst
//  os_sent     out  CNT_W        OS completed in current/last burst (wraps at 2^CNT_W)
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM to IDLE, counters 0; takes effect mid-burst with no OS completion.
//  - FSM: IDLE -> SEND on ts_start; SEND -> IDLE after symbol 15 when (ts_count!=0 && os_sent+1==ts_count)
//    or stop_pend set; ts_done pulses in the cycle after that symbol 15. No separate DONE state.
//  - Latency: ts_start sampled at edge t -> symbol 0 on tx_* at edge t+1. All outputs registered.
//  - Symbol index counter 0..15 wraps; OS back-to-back, no gap; tx_valid=1 throughout SEND.
//  - Symbols: 0 COM 8'hBC K=1; 1 link_num or PAD; 2 lane number or PAD; 3 n_fts; 4 rate_id;
//    5 train_ctl; 6..15 ident per ts_type. tx_k=1 only for COM and PAD symbols.
//  - ts_type, ts_count and all field inputs snapshot at ts_start; fields (not type/count) re-snapshot
//    at every symbol 0; changes mid-OS never affect the OS in flight.
//  - ts_stop: sets stop_pend; current OS completes through symbol 15. Stop in IDLE ignored; ts_stop
//    on the symbol-15 cycle ends the burst at that OS. Also honoured when ts_count!=0.
//  - ts_start while busy: ignored. ts_start and ts_stop same cycle in IDLE: one OS sent, then IDLE.
//  - os_sent clears at ts_start, increments at each symbol 15; wraps silently. ts_count=1 -> single OS.
//  - IDLE: tx_sym=0, tx_k=0, tx_valid=0, os_first=0.
// CONFIGURATION
//  TS_LANE_REV_EN defined: adds input lane_rev (1 bit, snapshotted with fields); when 1, lane i
//    sends lane_base+(LANE_NUM-1-i) in symbol 2. PAD still wins.
//  Undefined: no lane_rev port; lane i always sends lane_base+i.
// TESTING
//  1 Assert rst mid-idle and mid-burst -> all outputs 0 in same cycle, FSM idle, no ts_done.
//  2 LANE_NUM=4, TS1, ts_count=2, link=5, lane_base=0 -> 32 valid cycles; lane2 sym2=8'h02;
//    sym6..15=8'h4A; os_first at cycles 1,17; ts_done at cycle 33; os_sent=2.
//  3 TS2, pad_link=pad_lane=1, ts_count=1 -> sym1,sym2=8'hF7 with tx_k=1; sym6..15=8'h45, tx_k=0.
//  4 ts_count=0, ts_stop on symbol 7 of 3rd OS -> OS finishes at symbol 15, ts_done, os_sent=3.
//  5 link_num 5->9 at symbol 3 of OS1 -> OS1 symbol1=5, OS2 symbol1=9; ts_start while busy ignored.
//  6 TS_LANE_REV_EN, lane_rev=1, lane_base=8'hFE -> lanes0..3 sym2 = 8'h01,8'h00,8'hFF,8'hFE.

Source files
------------

// File: rtl/ts_os_gen.sv
// rtl/ts_os_gen.sv - TS1/TS2 training ordered-set generator for the LTSSM transmit path.
// Optional feature: define TS_LANE_REV_EN to add the lane_rev input (reversed lane numbering).
module ts_os_gen #(
    parameter int LANE_NUM = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ts_start,
    input  logic                  ts_stop,
    input  logic                  ts_type,
    input  logic [CNT_W-1:0]      ts_count,
    input  logic [7:0]            link_num,
    input  logic [7:0]            lane_base,
    input  logic                  pad_link,
    input  logic                  pad_lane,
    input  logic [7:0]            n_fts,
    input  logic [7:0]            rate_id,
    input  logic [7:0]            train_ctl,
`ifdef TS_LANE_REV_EN
    input  logic                  lane_rev,
`endif
    output logic [8*LANE_NUM-1:0] tx_sym,
    output logic [LANE_NUM-1:0]   tx_k,
    output logic                  tx_valid,
    output logic                  os_first,
    output logic                  ts_busy,
    output logic                  ts_done,
    output logic [CNT_W-1:0]      os_sent
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    logic [0:0]       state;
    logic [3:0]       idx;
    logic             first_q;
    logic             stop_pend;
    logic             type_q;
    logic [CNT_W-1:0] count_q;

    logic [7:0]       link_q;
    logic [7:0]       base_q;
    logic [7:0]       nfts_q;
    logic [7:0]       rate_q;
    logic [7:0]       tctl_q;
    logic             pad_link_q;
    logic             pad_lane_q;
    logic             rev_q;
    logic             rev_in;

`ifdef TS_LANE_REV_EN
    assign rev_in = lane_rev;
`else
    assign rev_in = 1'b0;
`endif

    // idx is the symbol emitted at the next edge; idx==0 after the first OS marks an OS boundary
    logic at_bound;
    logic os_end;
    logic snap;

    assign at_bound = (state == S_SEND) && (idx == 4'd0) && !first_q;
    assign os_end   = at_bound &&
                      (((count_q != '0) && (os_sent == count_q)) || stop_pend || ts_stop);
    assign snap     = ((state == S_IDLE) && ts_start) || (at_bound && !os_end);

    logic [8*LANE_NUM-1:0] sym_d;
    logic [LANE_NUM-1:0]   k_d;

    always_comb begin
        sym_d = '0;
        k_d   = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            case (idx)
                4'd0: begin
                    sym_d[8*i +: 8] = SYM_COM;
                    k_d[i]          = 1'b1;
                end
                4'd1: begin
                    sym_d[8*i +: 8] = pad_link_q ? SYM_PAD : link_q;
                    k_d[i]          = pad_link_q;
                end
                4'd2: begin
                    if (pad_lane_q) begin
                        sym_d[8*i +: 8] = SYM_PAD;
                        k_d[i]          = 1'b1;
                    end else if (rev_q) begin
                        sym_d[8*i +: 8] = base_q + 8'(LANE_NUM - 1 - i);
                    end else begin
                        sym_d[8*i +: 8] = base_q + 8'(i);
                    end
                end
                4'd3:    sym_d[8*i +: 8] = nfts_q;
                4'd4:    sym_d[8*i +: 8] = rate_q;
                4'd5:    sym_d[8*i +: 8] = tctl_q;
                default: sym_d[8*i +: 8] = type_q ? ID_TS2 : ID_TS1;
            endcase
        end
    end

    // Field snapshot: taken at ts_start and again at each later OS boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_q     <= '0;
            base_q     <= '0;
            nfts_q     <= '0;
            rate_q     <= '0;
            tctl_q     <= '0;
            pad_link_q <= 1'b0;
            pad_lane_q <= 1'b0;
            rev_q      <= 1'b0;
        end else if (snap) begin
            link_q     <= link_num;
            base_q     <= lane_base;
            nfts_q     <= n_fts;
            rate_q     <= rate_id;
            tctl_q     <= train_ctl;
            pad_link_q <= pad_link;
            pad_lane_q <= pad_lane;
            rev_q      <= rev_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            first_q   <= 1'b0;
            stop_pend <= 1'b0;
            type_q    <= 1'b0;
            count_q   <= '0;
            tx_sym    <= '0;
            tx_k      <= '0;
            tx_valid  <= 1'b0;
            os_first  <= 1'b0;
            ts_busy   <= 1'b0;
            ts_done   <= 1'b0;
            os_sent   <= '0;
        end else begin
            ts_done <= 1'b0;
            if (state == S_IDLE) begin
                tx_sym   <= '0;
                tx_k     <= '0;
                tx_valid <= 1'b0;
                os_first <= 1'b0;
                if (ts_start) begin
                    state     <= S_SEND;
                    ts_busy   <= 1'b1;
                    type_q    <= ts_type;
                    count_q   <= ts_count;
                    os_sent   <= '0;
                    idx       <= '0;
                    first_q   <= 1'b1;
                    stop_pend <= ts_stop;
                end
            end else if (os_end) begin
                state     <= S_IDLE;
                ts_busy   <= 1'b0;
                ts_done   <= 1'b1;
                stop_pend <= 1'b0;
                tx_sym    <= '0;
                tx_k      <= '0;
                tx_valid  <= 1'b0;
                os_first  <= 1'b0;
            end else begin
                tx_sym   <= sym_d;
                tx_k     <= k_d;
                tx_valid <= 1'b1;
                os_first <= (idx == 4'd0);
                first_q  <= 1'b0;
                idx      <= idx + 4'd1;
                if (idx == 4'd15)
                    os_sent <= os_sent + 1'b1;
                if (ts_stop)
                    stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ts_os_gen.sv
// tb/tb_ts_os_gen.sv - directed self-checking bench for ts_os_gen.
`timescale 1ns/1ps
module tb_ts_os_gen;

    localparam int LN = 4;
    localparam int CW = 16;
    localparam int MAXC = 120;

    logic            clk = 1'b0;
    logic            rst;
    logic            ts_start, ts_stop, ts_type;
    logic [CW-1:0]   ts_count;
    logic [7:0]      link_num, lane_base, n_fts, rate_id, train_ctl;
    logic            pad_link, pad_lane;
`ifdef TS_LANE_REV_EN
    logic            lane_rev;
`endif
    logic [8*LN-1:0] tx_sym;
    logic [LN-1:0]   tx_k;
    logic            tx_valid, os_first, ts_busy, ts_done;
    logic [CW-1:0]   os_sent;

    ts_os_gen #(.LANE_NUM(LN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ts_start(ts_start), .ts_stop(ts_stop), .ts_type(ts_type),
        .ts_count(ts_count), .link_num(link_num), .lane_base(lane_base),
        .pad_link(pad_link), .pad_lane(pad_lane), .n_fts(n_fts), .rate_id(rate_id),
        .train_ctl(train_ctl),
`ifdef TS_LANE_REV_EN
        .lane_rev(lane_rev),
`endif
        .tx_sym(tx_sym), .tx_k(tx_k), .tx_valid(tx_valid), .os_first(os_first),
        .ts_busy(ts_busy), .ts_done(ts_done), .os_sent(os_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]    cap_sym [0:MAXC][0:LN-1];
    logic [LN-1:0] cap_k   [0:MAXC];
    logic          cap_f   [0:MAXC];
    int            done_cyc;
    int            nvalid;
    int            nfirst;

    // Cycle c is the cycle after edge c; ts_start is sampled at edge 0.
    // stop_at / chg_at / restart_at drive inputs during that cycle (sampled at edge c+1).
    task automatic run_burst(input int stop_at, input int chg_at, input logic [7:0] chg_link,
                             input int restart_at);
        done_cyc = -1;
        nvalid   = 0;
        nfirst   = 0;
        ts_start = 1'b1;
        tick();
        ts_start = 1'b0;
        for (int c = 1; c <= MAXC && done_cyc < 0; c++) begin
            tick();
            for (int l = 0; l < LN; l++)
                cap_sym[c][l] = tx_sym[8*l +: 8];
            cap_k[c] = tx_k;
            cap_f[c] = os_first;
            if (tx_valid) nvalid++;
            if (os_first) nfirst++;
            if (ts_done) done_cyc = c;
            ts_stop  = (c == stop_at);
            ts_start = (c == restart_at);
            if (c == chg_at) link_num = chg_link;
        end
        ts_stop  = 1'b0;
        ts_start = 1'b0;
    endtask

    function automatic int ident_bad(input int last_c, input logic [7:0] id);
        int bad = 0;
        for (int c = 1; c <= last_c; c++)
            if (((c - 1) % 16) >= 6)
                for (int l = 0; l < LN; l++)
                    if (cap_sym[c][l] !== id || cap_k[c][l] !== 1'b0) bad++;
        return bad;
    endfunction

    initial begin
        rst = 1'b1;
        ts_start = 0; ts_stop = 0; ts_type = 0; ts_count = '0;
        link_num = 8'h05; lane_base = 8'h00; pad_link = 0; pad_lane = 0;
        n_fts = 8'h1F; rate_id = 8'h02; train_ctl = 8'h00;
`ifdef TS_LANE_REV_EN
        lane_rev = 1'b0;
`endif
        #1;
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_sym", tx_sym, 0);
        chk("rst_busy", {31'd0, ts_busy}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset mid-burst
        ts_count = '0;
        ts_start = 1'b1; tick(); ts_start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("pre_rst_valid", {31'd0, tx_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_sym", tx_sym, 0);
        chk("mid_rst_k", {28'd0, tx_k}, 0);
        chk("mid_rst_busy", {31'd0, ts_busy}, 0);
        chk("mid_rst_sent", {16'd0, os_sent}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_done", {31'd0, ts_done}, 0);
        chk("post_rst_valid", {31'd0, tx_valid}, 0);

        // TS1, two OS
        ts_type = 0; ts_count = 16'd2; link_num = 8'h05; lane_base = 8'h00;
        run_burst(-1, -1, 8'h00, -1);
        chk("t2_done_cyc", done_cyc, 33);
        chk("t2_nvalid", nvalid, 32);
        chk("t2_nfirst", nfirst, 2);
        chk("t2_first1", {31'd0, cap_f[1]}, 1);
        chk("t2_first17", {31'd0, cap_f[17]}, 1);
        chk("t2_com", {24'd0, cap_sym[1][3]}, 32'hBC);
        chk("t2_com_k", {28'd0, cap_k[1]}, 32'hF);
        chk("t2_link", {24'd0, cap_sym[2][1]}, 32'h05);
        chk("t2_link_k", {28'd0, cap_k[2]}, 0);
        chk("t2_lane2", {24'd0, cap_sym[3][2]}, 32'h02);
        chk("t2_lane3", {24'd0, cap_sym[19][3]}, 32'h03);
        chk("t2_nfts", {24'd0, cap_sym[4][0]}, 32'h1F);
        chk("t2_rate", {24'd0, cap_sym[5][1]}, 32'h02);
        chk("t2_ident", ident_bad(32, 8'h4A), 0);
        chk("t2_os_sent", {16'd0, os_sent}, 2);
        tick();
        chk("t2_idle_valid", {31'd0, tx_valid}, 0);
        chk("t2_idle_busy", {31'd0, ts_busy}, 0);
        chk("t2_done_pulse", {31'd0, ts_done}, 0);

        // TS2 with PAD on link and lane, single OS
        ts_type = 1; ts_count = 16'd1; pad_link = 1; pad_lane = 1;
        run_burst(-1, -1, 8'h00, -1);
        chk("t3_done_cyc", done_cyc, 17);
        chk("t3_pad_link", {24'd0, cap_sym[2][2]}, 32'hF7);
        chk("t3_pad_link_k", {28'd0, cap_k[2]}, 32'hF);
        chk("t3_pad_lane", {24'd0, cap_sym[3][0]}, 32'hF7);
        chk("t3_pad_lane_k", {28'd0, cap_k[3]}, 32'hF);
        chk("t3_nfts_k", {28'd0, cap_k[4]}, 0);
        chk("t3_ident", ident_bad(16, 8'h45), 0);
        chk("t3_os_sent", {16'd0, os_sent}, 1);
        pad_link = 0; pad_lane = 0; ts_type = 0;

        // stop in IDLE is ignored
        ts_stop = 1; tick(); ts_stop = 0; tick();
        chk("idle_stop_busy", {31'd0, ts_busy}, 0);
        chk("idle_stop_valid", {31'd0, tx_valid}, 0);

        // continuous, stop on symbol 7 of third OS (cycle 33+7)
        ts_count = 16'd0;
        run_burst(40, -1, 8'h00, -1);
        chk("t4_done_cyc", done_cyc, 49);
        chk("t4_nvalid", nvalid, 48);
        chk("t4_os_sent", {16'd0, os_sent}, 3);

        // field change mid-OS and ignored restart
        ts_count = 16'd2; link_num = 8'h05;
        run_burst(-1, 4, 8'h09, 10);
        chk("t5_os1_link", {24'd0, cap_sym[2][0]}, 32'h05);
        chk("t5_os2_link", {24'd0, cap_sym[18][0]}, 32'h09);
        chk("t5_done_cyc", done_cyc, 33);
        chk("t5_os_sent", {16'd0, os_sent}, 2);

        // lane numbering wrap (and reversal when compiled in)
        ts_count = 16'd1; lane_base = 8'hFE;
`ifdef TS_LANE_REV_EN
        lane_rev = 1'b1;
        run_burst(-1, -1, 8'h00, -1);
        chk("t6_lane0", {24'd0, cap_sym[3][0]}, 32'h01);
        chk("t6_lane1", {24'd0, cap_sym[3][1]}, 32'h00);
        chk("t6_lane2", {24'd0, cap_sym[3][2]}, 32'hFF);
        chk("t6_lane3", {24'd0, cap_sym[3][3]}, 32'hFE);
`else
        run_burst(-1, -1, 8'h00, -1);
        chk("t6_lane0", {24'd0, cap_sym[3][0]}, 32'hFE);
        chk("t6_lane1", {24'd0, cap_sym[3][1]}, 32'hFF);
        chk("t6_lane2", {24'd0, cap_sym[3][2]}, 32'h00);
        chk("t6_lane3", {24'd0, cap_sym[3][3]}, 32'h01);
`endif
        chk("t6_done_cyc", done_cyc, 17);

        // start and stop together in IDLE: exactly one OS
        ts_count = 16'd0;
        ts_stop = 1'b1;
        run_burst(-1, -1, 8'h00, -1);
        chk("t7_done_cyc", done_cyc, 17);
        chk("t7_os_sent", {16'd0, os_sent}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
